// File: rtl/sort4_seq.sv
// Sequential 4-element signed sorter: load four bytes, bubble-sort them with one
// shared comparator over six fixed steps, then drain in order. Optional swap_cnt under SORT4_SEQ_STATS_EN.

module eight_bit_comp (
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  output logic              G,
  output logic              Q,
  output logic              L
);
  assign G = (a > b);
  assign Q = (a == b);
  assign L = (a < b);
endmodule

module sort4_seq #(
  parameter bit DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
`ifdef SORT4_SEQ_STATS_EN
  ,
  output logic [2:0] swap_cnt
`endif
);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] step_q, step_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] r_q [4];
  logic [7:0] r_d [4];

  logic [1:0] left_sel;
  logic [1:0] right_sel;
  logic [7:0] cmp_a, cmp_b;
  logic       cmp_g, cmp_q, cmp_l;
  logic       do_swap;

  // Compare schedule is a 4-input bubble network: (0,1),(1,2),(2,3),(0,1),(1,2),(0,1)
  always_comb begin
    left_sel = 2'd0;
    case (step_q)
      3'd1, 3'd4: left_sel = 2'd1;
      3'd2:       left_sel = 2'd2;
      default:    left_sel = 2'd0;
    endcase
    right_sel = left_sel + 2'd1;
    cmp_a     = r_q[left_sel];
    cmp_b     = r_q[right_sel];
  end

  eight_bit_comp u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .G (cmp_g),
    .Q (cmp_q),
    .L (cmp_l)
  );

  // Ties never swap, which keeps equal elements in arrival order
  assign do_swap = !cmp_q && (DESCEND ? cmp_l : cmp_g);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    idx_d     = idx_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = 8'd0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r_d[cnt_q] = in_data;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = SORT;
            step_d  = 3'd0;
          end
        end
      end
      SORT: begin
        busy = 1'b1;
        if (do_swap) begin
          r_d[left_sel]  = cmp_b;
          r_d[right_sel] = cmp_a;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'd5) begin
          state_d = DRAIN;
          step_d  = 3'd0;
          idx_d   = 2'd0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_q[idx_q];
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = LOAD;
            cnt_d   = 2'd0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      step_q  <= 3'd0;
      idx_q   <= 2'd0;
      for (int i = 0; i < 4; i++) r_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
    end
  end

`ifdef SORT4_SEQ_STATS_EN
  logic [2:0] swap_cnt_q, swap_cnt_d;

  // Cleared on the accept that enters SORT, then held until the next set
  always_comb begin
    swap_cnt_d = swap_cnt_q;
    if (state_q == LOAD && in_valid && cnt_q == 2'd3)
      swap_cnt_d = 3'd0;
    else if (state_q == SORT && do_swap)
      swap_cnt_d = swap_cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) swap_cnt_q <= 3'd0;
    else        swap_cnt_q <= swap_cnt_d;
  end

  assign swap_cnt = swap_cnt_q;
`endif

endmodule

// File: tb/tb_sort4_seq.sv
// Self-checking bench for sort4_seq: ascending and descending instances share one
// input stream; table vectors, random sets against a rank-based model, and corner sequences.

module tb_sort4_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       in_ready_a, out_valid_a, busy_a;
  logic [7:0] out_data_a;
  logic       in_ready_d, out_valid_d, busy_d;
  logic [7:0] out_data_d;
`ifdef SORT4_SEQ_STATS_EN
  logic [2:0] swap_cnt_a, swap_cnt_d;
`endif

  int total_checks  = 0;
  int passed_checks = 0;

  sort4_seq #(.DESCEND(1'b0)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .busy      (busy_a)
`ifdef SORT4_SEQ_STATS_EN
    ,
    .swap_cnt  (swap_cnt_a)
`endif
  );

  sort4_seq #(.DESCEND(1'b1)) dut_d (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_d),
    .in_data   (in_data),
    .out_valid (out_valid_d),
    .out_ready (out_ready),
    .out_data  (out_data_d),
    .busy      (busy_d)
`ifdef SORT4_SEQ_STATS_EN
    ,
    .swap_cnt  (swap_cnt_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] din;
    logic [3:0][7:0] asc;
    logic [3:0][7:0] desc;
    int              sw_a;
    int              sw_d;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [3:0][7:0] pack4(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // Rank-based stable sort; swap count of a full bubble network equals the inversion count
  function automatic void sort_model(input logic [3:0][7:0] din, input bit desc,
                                     output logic [3:0][7:0] dout, output int swaps);
    int v[4];
    int pos;
    for (int i = 0; i < 4; i++) v[i] = int'($signed(din[i]));
    swaps = 0;
    dout  = '0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (desc ? (v[i] < v[j]) : (v[i] > v[j])) swaps++;
    for (int i = 0; i < 4; i++) begin
      pos = 0;
      for (int j = 0; j < 4; j++) begin
        if (desc ? (v[j] > v[i]) : (v[j] < v[i])) pos++;
        else if (v[j] == v[i] && j < i) pos++;
      end
      dout[pos] = din[i];
    end
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic loadSet(input logic [3:0][7:0] din);
    int n;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("load_in_ready", int'(in_ready_a & in_ready_d), 1);
      checkOutput("load_busy", int'(busy_a | busy_d), 0);
      in_valid = 1'b1;
      in_data  = din[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    checkOutput("sort_busy", int'(busy_a & busy_d), 1);
    checkOutput("sort_in_ready", int'(in_ready_a | in_ready_d), 0);
    checkOutput("sort_out_data", int'(out_data_a), 0);
    n = 0;
    while (!out_valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("out_valid_latency", n, 6);
  endtask

  task automatic drainSet(input logic [3:0][7:0] asc, input logic [3:0][7:0] desc,
                          input int sw_a, input int sw_d, input bit rand_stall);
    int i;
    int cycles;
    i = 0;
    cycles = 0;
`ifdef SORT4_SEQ_STATS_EN
    checkOutput("swap_cnt_asc", int'(swap_cnt_a), sw_a);
    checkOutput("swap_cnt_desc", int'(swap_cnt_d), sw_d);
`endif
    while (i < 4 && cycles < 200) begin
      checkOutput("drain_valid", int'(out_valid_a & out_valid_d), 1);
      checkOutput("drain_data_asc", int'(out_data_a), int'(asc[i]));
      checkOutput("drain_data_desc", int'(out_data_d), int'(desc[i]));
      checkOutput("drain_in_ready", int'(in_ready_a | in_ready_d), 0);
      out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 8'($urandom);
      @(negedge clk);
      if (out_ready) i++;
      cycles++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("drain_count", i, 4);
    checkOutput("idle_out_valid", int'(out_valid_a | out_valid_d), 0);
    checkOutput("idle_out_data", int'(out_data_a | out_data_d), 0);
    checkOutput("idle_in_ready", int'(in_ready_a & in_ready_d), 1);
`ifdef SORT4_SEQ_STATS_EN
    checkOutput("swap_cnt_hold_asc", int'(swap_cnt_a), sw_a);
    checkOutput("swap_cnt_hold_desc", int'(swap_cnt_d), sw_d);
`endif
  endtask

  task automatic applyStimulus(input logic [3:0][7:0] din, input logic [3:0][7:0] asc,
                               input logic [3:0][7:0] desc, input int sw_a, input int sw_d,
                               input bit rand_stall);
    loadSet(din);
    drainSet(asc, desc, sw_a, sw_d, rand_stall);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, int'(out_valid_a | out_valid_d), 0);
    checkOutput({tag, "_out_data"}, int'(out_data_a | out_data_d), 0);
    checkOutput({tag, "_busy"}, int'(busy_a | busy_d), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready_a & in_ready_d), 1);
  endtask

  initial begin
    logic [3:0][7:0] din, asc, desc, q0, q1;
    int sw_a, sw_d, ptr, nout, cycles, overlap;
    logic [7:0] got_a[8];
    logic [7:0] got_d[8];

    vecs[0] = '{pack4(8'h05, 8'hFD, 8'h7F, 8'h80), pack4(8'h80, 8'hFD, 8'h05, 8'h7F),
                pack4(8'h7F, 8'h05, 8'hFD, 8'h80), 4, 2};
    vecs[1] = '{pack4(8'h01, 8'h02, 8'h03, 8'h04), pack4(8'h01, 8'h02, 8'h03, 8'h04),
                pack4(8'h04, 8'h03, 8'h02, 8'h01), 0, 6};
    vecs[2] = '{pack4(8'h7F, 8'h00, 8'hFF, 8'h80), pack4(8'h80, 8'hFF, 8'h00, 8'h7F),
                pack4(8'h7F, 8'h00, 8'hFF, 8'h80), 6, 0};
    vecs[3] = '{pack4(8'h80, 8'h80, 8'h80, 8'h80), pack4(8'h80, 8'h80, 8'h80, 8'h80),
                pack4(8'h80, 8'h80, 8'h80, 8'h80), 0, 0};
    vecs[4] = '{pack4(8'h04, 8'h03, 8'h02, 8'h01), pack4(8'h01, 8'h02, 8'h03, 8'h04),
                pack4(8'h04, 8'h03, 8'h02, 8'h01), 6, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    #12;
    checkResetOutputs("reset");
`ifdef SORT4_SEQ_STATS_EN
    checkOutput("reset_swap_cnt", int'(swap_cnt_a | swap_cnt_d), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int v = 0; v < 5; v++)
      applyStimulus(vecs[v].din, vecs[v].asc, vecs[v].desc, vecs[v].sw_a, vecs[v].sw_d, 1'b0);

    $display("[TB] output stall at idx 1");
    din  = pack4(8'h0A, 8'hEC, 8'h1E, 8'hD8);
    asc  = pack4(8'hD8, 8'hEC, 8'h0A, 8'h1E);
    desc = pack4(8'h1E, 8'h0A, 8'hEC, 8'hD8);
    loadSet(din);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clk);
      checkOutput("stall_data_asc", int'(out_data_a), int'(asc[1]));
      checkOutput("stall_data_desc", int'(out_data_d), int'(desc[1]));
      checkOutput("stall_in_ready", int'(in_ready_a | in_ready_d), 0);
      checkOutput("stall_out_valid", int'(out_valid_a & out_valid_d), 1);
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checkOutput("resume_data_asc", int'(out_data_a), int'(asc[i]));
      checkOutput("resume_data_desc", int'(out_data_d), int'(desc[i]));
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("resume_done_in_ready", int'(in_ready_a & in_ready_d), 1);
    applyStimulus(vecs[1].din, vecs[1].asc, vecs[1].desc, vecs[1].sw_a, vecs[1].sw_d, 1'b0);

    $display("[TB] reset mid-LOAD");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h11 * 8'(k + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(vecs[0].din, vecs[0].asc, vecs[0].desc, vecs[0].sw_a, vecs[0].sw_d, 1'b0);

    $display("[TB] reset mid-SORT");
    din = pack4(8'h09, 8'h08, 8'h07, 8'h06);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = din[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("rst_sort");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(vecs[4].din, vecs[4].asc, vecs[4].desc, vecs[4].sw_a, vecs[4].sw_d, 1'b0);

    $display("[TB] random sets");
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 4; k++)
        din[k] = (r % 2 == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 2)) - 1);
      sort_model(din, 1'b0, asc, sw_a);
      sort_model(din, 1'b1, desc, sw_d);
      applyStimulus(din, asc, desc, sw_a, sw_d, 1'b1);
    end

    $display("[TB] back-to-back sets with in_valid held");
    for (int k = 0; k < 4; k++) begin
      q0[k] = 8'($urandom);
      q1[k] = 8'($urandom);
    end
    ptr = 0;
    nout = 0;
    cycles = 0;
    overlap = 0;
    out_ready = 1'b1;
    while ((ptr < 8 || nout < 8) && cycles < 500) begin
      @(negedge clk);
      in_valid = (ptr < 8);
      in_data  = (ptr < 4) ? q0[ptr] : (ptr < 8 ? q1[ptr - 4] : 8'd0);
      if (in_ready_a && out_valid_a) overlap++;
      if (in_ready_a && in_valid) begin
        if (ptr == 4) checkOutput("fifth_accept_after_drain", nout, 4);
        ptr++;
      end
      if (out_valid_a && nout < 8) begin
        got_a[nout] = out_data_a;
        got_d[nout] = out_data_d;
        nout++;
      end
      cycles++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_outputs", nout, 8);
    checkOutput("b2b_in_out_overlap", overlap, 0);
    sort_model(q0, 1'b0, asc, sw_a);
    sort_model(q0, 1'b1, desc, sw_d);
    for (int i = 0; i < 4; i++) begin
      checkOutput("b2b_set0_asc", int'(got_a[i]), int'(asc[i]));
      checkOutput("b2b_set0_desc", int'(got_d[i]), int'(desc[i]));
    end
    sort_model(q1, 1'b0, asc, sw_a);
    sort_model(q1, 1'b1, desc, sw_d);
    for (int i = 0; i < 4; i++) begin
      checkOutput("b2b_set1_asc", int'(got_a[i + 4]), int'(asc[i]));
      checkOutput("b2b_set1_desc", int'(got_d[i + 4]), int'(desc[i]));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
